// File: rtl/ghr_pkg.sv
// Shared types and helpers for the speculative global history register.
// Provides default history length / in-flight depth, the history type and
// the shift helper (newest direction enters the MSB).
package ghr_pkg;

  localparam int GHR_W_DEF        = 5;
  localparam int MAX_INFLIGHT_DEF = 4;

  typedef logic [GHR_W_DEF-1:0] ghr_t;

  // Newest branch direction enters at the MSB, oldest falls off the LSB.
  function automatic ghr_t ghr_shift(ghr_t h, logic b);
    return {b, h[GHR_W_DEF-1:1]};
  endfunction

endpackage

// File: rtl/ghr_pred_fifo.sv
// 1-bit synchronous FIFO holding predicted directions of unresolved branches.
// Latency: push visible at o_dout/o_count the cycle after the push edge.
// Backpressure: caller must gate i_push with !o_full and i_pop with !o_empty.
// Ports: clk, rst_n (sync, active-low), i_push/i_din, i_pop/o_dout,
//        i_clear (drops all entries, wins over push/pop), o_count, o_full, o_empty.
module ghr_pred_fifo
  import ghr_pkg::*;
#(
  parameter int DEPTH = MAX_INFLIGHT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_din,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic                       o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // and the count falls out of a plain subtraction.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [DEPTH-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/spec_global_history_register.sv
// Speculative + architectural global branch history with in-order repair.
// Latency: all history/count/flag updates visible 1 cycle after the input edge.
// Backpressure: pred_ready drops when MAX_INFLIGHT branches are unresolved.
// Ports: pred_valid/pred_taken/pred_ready (prediction push), resolve_valid/
//        resolve_taken (in-order resolution), flush (squash all in-flight),
//        ghr_spec_idx, ghr_arch, mispredict (pulse), inflight_cnt, resolve_err.
// Option: define GHR_PERF_CNT_EN to add saturating perf_resolved/perf_mispred.
module spec_global_history_register
  import ghr_pkg::*;
#(
  parameter int GHR_W        = GHR_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pred_valid,
  input  logic                            pred_taken,
  output logic                            pred_ready,
  input  logic                            resolve_valid,
  input  logic                            resolve_taken,
  input  logic                            flush,
  output logic [GHR_W-1:0]                ghr_spec_idx,
  output logic [GHR_W-1:0]                ghr_arch,
  output logic                            mispredict,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight_cnt,
`ifdef GHR_PERF_CNT_EN
  output logic [15:0]                     perf_resolved,
  output logic [15:0]                     perf_mispred,
`endif
  output logic                            resolve_err
);

  // Width-generic version of the package shift rule.
  function automatic logic [GHR_W-1:0] shift_in(logic [GHR_W-1:0] h, logic b);
    return {b, h[GHR_W-1:1]};
  endfunction

  logic [GHR_W-1:0] r_spec;
  logic [GHR_W-1:0] r_arch;
  logic             r_mispredict;
  logic             r_resolve_err;

  logic             w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pred_acc;
  logic             w_res;
  logic             w_mis;
  logic             w_squash;
  logic [GHR_W-1:0] w_arch_nxt;

  assign pred_ready = !w_fifo_full;
  assign w_pred_acc = pred_valid && pred_ready;
  assign w_res      = resolve_valid && !w_fifo_empty;
  assign w_mis      = w_res && (w_fifo_dout != resolve_taken);
  assign w_arch_nxt = w_res ? shift_in(r_arch, resolve_taken) : r_arch;
  // Mispredict and external flush repair identically: both restore the
  // speculative copy from the post-resolve architectural value.
  assign w_squash   = w_mis || flush;

  ghr_pred_fifo #(.DEPTH(MAX_INFLIGHT)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_pred_acc && !w_squash),
    .i_din   (pred_taken),
    .i_pop   (w_res),
    .i_clear (w_squash),
    .o_dout  (w_fifo_dout),
    .o_count (inflight_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spec        <= '0;
      r_arch        <= '0;
      r_mispredict  <= 1'b0;
      r_resolve_err <= 1'b0;
    end else begin
      r_arch       <= w_arch_nxt;
      r_mispredict <= w_mis;
      if (resolve_valid && w_fifo_empty) r_resolve_err <= 1'b1;
      if (w_squash)        r_spec <= w_arch_nxt;
      else if (w_pred_acc) r_spec <= shift_in(r_spec, pred_taken);
    end
  end

`ifdef GHR_PERF_CNT_EN
  logic [15:0] r_perf_resolved;
  logic [15:0] r_perf_mispred;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_resolved <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (w_res && (r_perf_resolved != 16'hFFFF)) r_perf_resolved <= r_perf_resolved + 16'd1;
      if (w_mis && (r_perf_mispred  != 16'hFFFF)) r_perf_mispred  <= r_perf_mispred  + 16'd1;
    end
  end

  assign perf_resolved = r_perf_resolved;
  assign perf_mispred  = r_perf_mispred;
`endif

  assign ghr_spec_idx = r_spec;
  assign ghr_arch     = r_arch;
  assign mispredict   = r_mispredict;
  assign resolve_err  = r_resolve_err;

endmodule

// File: tb/tb_spec_global_history_register.sv
// Randomised + directed bench for the speculative GHR against a queue-based model.
module tb_spec_global_history_register;

  localparam int W    = 5;
  localparam int MAXI = 4;
  localparam int CW   = $clog2(MAXI) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pred_valid, pred_taken, pred_ready;
  logic          resolve_valid, resolve_taken, flush;
  logic [W-1:0]  ghr_spec_idx, ghr_arch;
  logic          mispredict;
  logic [CW-1:0] inflight_cnt;
  logic          resolve_err;
`ifdef GHR_PERF_CNT_EN
  logic [15:0]   perf_resolved, perf_mispred;
`endif

  always #5 clk = ~clk;

  spec_global_history_register #(.GHR_W(W), .MAX_INFLIGHT(MAXI)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .ghr_spec_idx  (ghr_spec_idx),
    .ghr_arch      (ghr_arch),
    .mispredict    (mispredict),
    .inflight_cnt  (inflight_cnt),
`ifdef GHR_PERF_CNT_EN
    .perf_resolved (perf_resolved),
    .perf_mispred  (perf_mispred),
`endif
    .resolve_err   (resolve_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: in-flight predictions as a queue, histories as integers.
  bit q[$];
  int m_spec, m_arch;
  bit m_mis, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hshift(int h, bit b);
    return (h >> 1) | (int'(b) << (W - 1));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_spec"},  32'(ghr_spec_idx), 32'(m_spec));
    chk({tag, "_arch"},  32'(ghr_arch),     32'(m_arch));
    chk({tag, "_cnt"},   32'(inflight_cnt), 32'(q.size()));
    chk({tag, "_rdy"},   32'(pred_ready),   32'(q.size() != MAXI));
    chk({tag, "_mis"},   32'(mispredict),   32'(m_mis));
    chk({tag, "_err"},   32'(resolve_err),  32'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, check.
  task automatic step(input bit rst, input bit pv, input bit pt,
                      input bit rv, input bit rt, input bit fl, input string tag);
    bit acc, res, mis, popped;
    rst_n = !rst; pred_valid = pv; pred_taken = pt;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    if (rst) begin
      q.delete(); m_spec = 0; m_arch = 0; m_mis = 0; m_err = 0;
    end else begin
      acc = pv && (q.size() != MAXI);
      res = rv && (q.size() > 0);
      mis = 1'b0;
      if (rv && q.size() == 0) m_err = 1'b1;
      if (res) begin
        popped = q.pop_front();
        mis    = (popped != rt);
        m_arch = hshift(m_arch, rt);
      end
      if (mis || fl) begin
        q.delete();
        m_spec = m_arch;
      end else if (acc) begin
        q.push_back(pt);
        m_spec = hshift(m_spec, pt);
      end
      m_mis = mis;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit pv, pt, rv, rt, fl, rs;
    rst_n = 1'b0; pred_valid = 0; pred_taken = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, "reset");
    step(1, 0, 0, 0, 0, 0, "reset2");

    // Predict T,T,N
    step(0, 1, 1, 0, 0, 0, "p1"); chk("p1_lit", 32'(ghr_spec_idx), 32'h10);
    step(0, 1, 1, 0, 0, 0, "p2"); chk("p2_lit", 32'(ghr_spec_idx), 32'h18);
    step(0, 1, 0, 0, 0, 0, "p3"); chk("p3_lit", 32'(ghr_spec_idx), 32'h0C);
    // Resolve T,T,N correctly
    step(0, 0, 0, 1, 1, 0, "r1");
    step(0, 0, 0, 1, 1, 0, "r2");
    step(0, 0, 0, 1, 0, 0, "r3");
    chk("r3_arch_lit", 32'(ghr_arch), 32'h0C);
    chk("r3_cnt_lit",  32'(inflight_cnt), 32'd0);

    // Mispredict repair from fresh reset
    step(1, 0, 0, 0, 0, 0, "rst_b");
    step(0, 1, 1, 0, 0, 0, "m_p1");
    step(0, 1, 1, 0, 0, 0, "m_p2");
    step(0, 1, 1, 0, 0, 0, "m_p3");
    step(0, 1, 1, 1, 0, 0, "m_res");   // same-cycle prediction squashed
    chk("m_mis_lit", 32'(mispredict), 32'd1);
    chk("m_spec_lit", 32'(ghr_spec_idx), 32'd0);
    step(0, 0, 0, 0, 0, 0, "m_after");

    // Fill to full, rejected 5th, then resolve (+ blocked pred), then resolve+pred
    for (int i = 0; i < MAXI; i++) step(0, 1, i[0], 0, 0, 0, "fill");
    step(0, 1, 1, 0, 0, 0, "full_rej");
    chk("full_rdy_lit", 32'(pred_ready), 32'd0);
    step(0, 1, 1, 1, q[0], 0, "full_res");
    step(0, 1, 0, 1, q[0], 0, "res_pred");
    chk("res_pred_cnt_lit", 32'(inflight_cnt), 32'd3);

    // Flush with arch=10100 and two in flight
    step(1, 0, 0, 0, 0, 0, "rst_c");
    step(0, 1, 1, 0, 0, 0, "f_p1");
    step(0, 1, 0, 0, 0, 0, "f_p2");
    step(0, 1, 1, 0, 0, 0, "f_p3");
    step(0, 0, 0, 1, 1, 0, "f_r1");
    step(0, 0, 0, 1, 0, 0, "f_r2");
    step(0, 0, 0, 1, 1, 0, "f_r3");
    step(0, 1, 0, 0, 0, 0, "f_p4");
    step(0, 1, 0, 0, 0, 0, "f_p5");
    step(0, 1, 1, 0, 0, 1, "flush");
    chk("flush_spec_lit", 32'(ghr_spec_idx), 32'h14);
    // Flush coincident with a mispredicting resolve
    step(0, 1, 1, 0, 0, 0, "fm_p");
    step(0, 1, 1, 1, 0, 1, "fm_both");

    // Resolve on empty FIFO: sticky error, then reset clears it
    step(1, 0, 0, 0, 0, 0, "rst_d");
    step(0, 0, 0, 1, 1, 0, "err_set");
    step(0, 0, 0, 0, 0, 0, "err_hold");
    step(1, 0, 0, 0, 0, 0, "err_clr");

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      rs = ($urandom_range(0, 149) == 0);
      pv = ($urandom_range(0, 2) != 0);
      pt = $urandom_range(0, 1);
      rv = ($urandom_range(0, 1) != 0);
      rt = (q.size() > 0 && $urandom_range(0, 4) != 0) ? q[0] : 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 31) == 0);
      step(rs, pv, pt, rv, rt, fl, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
